// File: rtl/bram_rr_arbiter_pkg.sv
// Shared types and widths for the two-port BRAM round-robin arbiter.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_t;

  localparam int unsigned RUN_W  = 3;
  localparam int unsigned STAT_W = 16;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

endpackage

// File: rtl/bram_rr_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the BRAM macro.
interface bram_rr_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              REQ0_VALID, REQ1_VALID;
  logic              REQ0_WRITE, REQ1_WRITE;
  logic              REQ0_LOCK,  REQ1_LOCK;
  logic [ADDR_W-1:0] REQ0_ADDR,  REQ1_ADDR;
  logic [DATA_W-1:0] REQ0_WDATA, REQ1_WDATA;
  logic [BE_W-1:0]   REQ0_BE,    REQ1_BE;
  logic              REQ0_READY, REQ1_READY;
  logic              RSP0_VALID, RSP1_VALID;
  logic [DATA_W-1:0] RSP0_RDATA, RSP1_RDATA;
  logic              BRAM_EN;
  logic [BE_W-1:0]   BRAM_WE;
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_WDATA;
  logic [DATA_W-1:0] BRAM_RDATA;

  modport master (
    output REQ0_VALID, REQ0_WRITE, REQ0_LOCK, REQ0_ADDR, REQ0_WDATA, REQ0_BE,
    output REQ1_VALID, REQ1_WRITE, REQ1_LOCK, REQ1_ADDR, REQ1_WDATA, REQ1_BE,
    input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_RDATA, RSP1_RDATA,
    input  BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_WDATA,
    output BRAM_RDATA
  );

  modport slave (
    input  REQ0_VALID, REQ0_WRITE, REQ0_LOCK, REQ0_ADDR, REQ0_WDATA, REQ0_BE,
    input  REQ1_VALID, REQ1_WRITE, REQ1_LOCK, REQ1_ADDR, REQ1_WDATA, REQ1_BE,
    output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_RDATA, RSP1_RDATA,
    output BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_WDATA,
    input  BRAM_RDATA
  );

endinterface

// File: rtl/bram_rr_arbiter_pick.sv
// Combinational winner selection: round-robin with a bounded ownership lock.
module bram_arb_pick
  import bram_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic [1:0]       valid,
  input  logic [1:0]       lock,
  input  owner_t           owner,
  input  logic [RUN_W-1:0] run,
  output logic [1:0]       gnt
);

  logic under_limit;

  assign under_limit = 32'(run) < HOLD_MAX;

  always_comb begin
    gnt = 2'b00;
    case (valid)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Contended: owner keeps the bus only while locked and under the beat bound.
        case (owner)
          OWN0:    gnt = (lock[0] && under_limit) ? 2'b01 : 2'b10;
          OWN1:    gnt = (lock[1] && under_limit) ? 2'b10 : 2'b01;
          default: gnt = 2'b01;
        endcase
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-port read-first BRAM.
// Optional grant/conflict counters are built when ARB_STATS_EN is defined.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef ARB_STATS_EN
  input  logic              STAT_CLR,
  output logic [STAT_W-1:0] STAT_GNT0,
  output logic [STAT_W-1:0] STAT_GNT1,
  output logic [STAT_W-1:0] STAT_CONFLICT,
`endif
  bram_rr_arbiter_if.slave  bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [1:0]        valid;
  logic [1:0]        lock;
  logic [1:0]        gnt;
  owner_t            owner_q, owner_d, win_owner;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [1:0]        rd_pend_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [BE_W-1:0]   we_sel;

  // Gating with RESET keeps every handshake and BRAM output quiet while held in reset.
  assign valid = {bus.REQ1_VALID, bus.REQ0_VALID} & {2{RESET}};
  assign lock  = {bus.REQ1_LOCK, bus.REQ0_LOCK};

  bram_arb_pick #(
    .HOLD_MAX (HOLD_MAX)
  ) u_pick (
    .valid (valid),
    .lock  (lock),
    .owner (owner_q),
    .run   (run_q),
    .gnt   (gnt)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      owner_q <= IDLE;
      run_q   <= '0;
    end else begin
      owner_q <= owner_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    owner_d   = IDLE;
    run_d     = '0;
    win_owner = IDLE;
    if (gnt[0])      win_owner = OWN0;
    else if (gnt[1]) win_owner = OWN1;
    if (win_owner != IDLE) begin
      owner_d = win_owner;
      if (win_owner == owner_q) run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      else                      run_d = RUN_W'(1);
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = '0;
    if (gnt[0]) begin
      addr_sel  = bus.REQ0_ADDR;
      wdata_sel = bus.REQ0_WDATA;
      we_sel    = bus.REQ0_WRITE ? bus.REQ0_BE : '0;
    end else if (gnt[1]) begin
      addr_sel  = bus.REQ1_ADDR;
      wdata_sel = bus.REQ1_WDATA;
      we_sel    = bus.REQ1_WRITE ? bus.REQ1_BE : '0;
    end
  end

  assign bus.REQ0_READY = gnt[0];
  assign bus.REQ1_READY = gnt[1];
  assign bus.BRAM_EN    = |gnt;
  assign bus.BRAM_WE    = we_sel;
  assign bus.BRAM_ADDR  = addr_sel;
  assign bus.BRAM_WDATA = wdata_sel;

  // One flag per port marks a read whose data the BRAM presents next cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rd_pend_q <= '0;
    else        rd_pend_q <= gnt & ~{bus.REQ1_WRITE, bus.REQ0_WRITE};
  end

  assign bus.RSP0_VALID = rd_pend_q[0];
  assign bus.RSP1_VALID = rd_pend_q[1];
  assign bus.RSP0_RDATA = rd_pend_q[0] ? bus.BRAM_RDATA : '0;
  assign bus.RSP1_RDATA = rd_pend_q[1] ? bus.BRAM_RDATA : '0;

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      STAT_GNT0     <= '0;
      STAT_GNT1     <= '0;
      STAT_CONFLICT <= '0;
    end else if (STAT_CLR) begin
      STAT_GNT0     <= '0;
      STAT_GNT1     <= '0;
      STAT_CONFLICT <= '0;
    end else begin
      if (gnt[0] && STAT_GNT0 != '1)          STAT_GNT0     <= STAT_GNT0 + 1'b1;
      if (gnt[1] && STAT_GNT1 != '1)          STAT_GNT1     <= STAT_GNT1 + 1'b1;
      if ((&valid) && STAT_CONFLICT != '1)    STAT_CONFLICT <= STAT_CONFLICT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Scoreboard bench for bram_rr_arbiter with a behavioural read-first BRAM.
module tb_bram_rr_arbiter;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  int unsigned exp_gnt[$];
  logic [31:0] exp_rsp0[$];
  logic [31:0] exp_rsp1[$];
  logic [31:0] mem [0:4095];

  bram_rr_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

`ifdef ARB_STATS_EN
  logic        STAT_CLR = 1'b0;
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  bram_rr_arbiter #(.ADDR_W(12), .DATA_W(32), .HOLD_MAX(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
`ifdef ARB_STATS_EN
    .STAT_CLR      (STAT_CLR),
    .STAT_GNT0     (stat_gnt0),
    .STAT_GNT1     (stat_gnt1),
    .STAT_CONFLICT (stat_conflict),
`endif
    .bus           (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.BRAM_EN) begin
      bus.BRAM_RDATA <= mem[bus.BRAM_ADDR];
      for (int b = 0; b < 4; b++)
        if (bus.BRAM_WE[b]) mem[bus.BRAM_ADDR][8*b +: 8] <= bus.BRAM_WDATA[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic report_extra(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected output, expected nothing queued", name);
  endtask

  task automatic issue(input int p, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic lk);
    int unsigned n = 0;
    if (p == 0) begin
      bus.REQ0_VALID = 1'b1; bus.REQ0_WRITE = wr; bus.REQ0_ADDR = a;
      bus.REQ0_WDATA = d;    bus.REQ0_BE = be;    bus.REQ0_LOCK = lk;
    end else begin
      bus.REQ1_VALID = 1'b1; bus.REQ1_WRITE = wr; bus.REQ1_ADDR = a;
      bus.REQ1_WDATA = d;    bus.REQ1_BE = be;    bus.REQ1_LOCK = lk;
    end
    forever begin
      @(negedge CLK);
      if ((p == 0) ? bus.REQ0_READY : bus.REQ1_READY) break;
      n++;
      if (n > 60) begin
        vectors++;
        miscompares++;
        $display("FAIL issue_timeout port%0d: got no ready, expected ready", p);
        break;
      end
    end
    @(posedge CLK); #1;
    if (p == 0) begin bus.REQ0_VALID = 1'b0; bus.REQ0_LOCK = 1'b0; end
    else        begin bus.REQ1_VALID = 1'b0; bus.REQ1_LOCK = 1'b0; end
  endtask

  task automatic wr0(input logic [11:0] a, input logic [31:0] d);
    exp_gnt.push_back(0);
    issue(0, 1'b1, a, d, 4'hF, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: grants, BRAM drive and read responses against the queued expectations.
  initial begin : monitor
    logic [1:0]  prev_rd;
    logic [1:0]  exp_rv;
    int unsigned w;
    prev_rd = '0;
    forever begin
      @(negedge CLK);
      exp_rv = prev_rd & {2{RESET}};
      if (exp_rv[0] || bus.RSP0_VALID) begin
        check("rsp0_valid", 32'(bus.RSP0_VALID), 32'(exp_rv[0]));
        if (bus.RSP0_VALID) begin
          if (exp_rsp0.size() == 0) report_extra("rsp0_data");
          else check("rsp0_data", bus.RSP0_RDATA, exp_rsp0.pop_front());
        end
      end
      if (exp_rv[1] || bus.RSP1_VALID) begin
        check("rsp1_valid", 32'(bus.RSP1_VALID), 32'(exp_rv[1]));
        if (bus.RSP1_VALID) begin
          if (exp_rsp1.size() == 0) report_extra("rsp1_data");
          else check("rsp1_data", bus.RSP1_RDATA, exp_rsp1.pop_front());
        end
      end
      if (!bus.RSP0_VALID && bus.RSP0_RDATA != '0) check("rsp0_rdata_idle", bus.RSP0_RDATA, '0);
      if (!bus.RSP1_VALID && bus.RSP1_RDATA != '0) check("rsp1_rdata_idle", bus.RSP1_RDATA, '0);
      if (bus.REQ0_READY || bus.REQ1_READY) begin
        w = bus.REQ1_READY ? 1 : 0;
        check("single_grant", 32'(bus.REQ0_READY & bus.REQ1_READY), '0);
        check("bram_en", 32'(bus.BRAM_EN), 32'd1);
        check("bram_addr", 32'(bus.BRAM_ADDR), 32'(w != 0 ? bus.REQ1_ADDR : bus.REQ0_ADDR));
        check("bram_we", 32'(bus.BRAM_WE),
              32'(w != 0 ? (bus.REQ1_WRITE ? bus.REQ1_BE : 4'h0)
                         : (bus.REQ0_WRITE ? bus.REQ0_BE : 4'h0)));
        if (exp_gnt.size() == 0) report_extra("grant");
        else check("grant", w, exp_gnt.pop_front());
      end else if (bus.BRAM_EN || bus.BRAM_WE != '0 || bus.BRAM_ADDR != '0 || bus.BRAM_WDATA != '0) begin
        check("bram_idle", 32'(bus.BRAM_EN) | 32'(bus.BRAM_WE) | 32'(bus.BRAM_ADDR) | bus.BRAM_WDATA, '0);
      end
      prev_rd = {bus.REQ1_READY & ~bus.REQ1_WRITE, bus.REQ0_READY & ~bus.REQ0_WRITE};
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int g4[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    bus.REQ0_VALID = 0; bus.REQ0_WRITE = 0; bus.REQ0_LOCK = 0;
    bus.REQ0_ADDR = '0; bus.REQ0_WDATA = '0; bus.REQ0_BE = '0;
    bus.REQ1_VALID = 0; bus.REQ1_WRITE = 0; bus.REQ1_LOCK = 0;
    bus.REQ1_ADDR = '0; bus.REQ1_WDATA = '0; bus.REQ1_BE = '0;

    // Reset with both ports requesting; port 0 must win the first cycle after release.
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    fork
      issue(0, 1'b1, 12'h010, 32'hCAFE_0001, 4'hF, 1'b0);
      issue(1, 1'b1, 12'h011, 32'h1234_5678, 4'hF, 1'b0);
      begin
        repeat (2) @(negedge CLK);
        check("rst_ready0", 32'(bus.REQ0_READY), '0);
        check("rst_ready1", 32'(bus.REQ1_READY), '0);
        check("rst_bram_en", 32'(bus.BRAM_EN), '0);
        check("rst_rsp_valid", 32'({bus.RSP1_VALID, bus.RSP0_VALID}), '0);
        @(posedge CLK); #1;
        RESET = 1'b1;
      end
    join
    gap(2);

    // Single read from port 1.
    exp_gnt.push_back(1);
    exp_rsp1.push_back(32'hCAFE_0001);
    issue(1, 1'b0, 12'h010, '0, 4'h0, 1'b0);
    gap(2);

    for (int i = 0; i < 4; i++) wr0(12'(12'h100 + i), 32'hA000_0100 + i);
    for (int i = 0; i < 4; i++) wr0(12'(12'h200 + i), 32'hB000_0200 + i);
    for (int i = 0; i < 10; i++) wr0(12'(12'h300 + i), 32'hC000_0300 + i);
    for (int i = 0; i < 3; i++) wr0(12'(12'h310 + i), 32'hD000_0310 + i);
    gap(2);

    // Unlocked contention alternates 0,1,0,1...
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
      exp_rsp0.push_back(32'hA000_0100 + i);
      exp_rsp1.push_back(32'hB000_0200 + i);
    end
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 12'(12'h100 + i), '0, 4'h0, 1'b0);
      for (int j = 0; j < 4; j++) issue(1, 1'b0, 12'(12'h200 + j), '0, 4'h0, 1'b0);
    join
    gap(2);

    // Locked port 0 is held to 4 beats while port 1 waits.
    foreach (g4[k]) exp_gnt.push_back(g4[k]);
    for (int i = 0; i < 10; i++) exp_rsp0.push_back(32'hC000_0300 + i);
    for (int i = 0; i < 3; i++) exp_rsp1.push_back(32'hD000_0310 + i);
    fork
      for (int i = 0; i < 10; i++) issue(0, 1'b0, 12'(12'h300 + i), '0, 4'h0, 1'b1);
      for (int j = 0; j < 3; j++) issue(1, 1'b0, 12'(12'h310 + j), '0, 4'h0, 1'b0);
    join
    gap(2);

    // Byte-enable write, then read-before-write ordering across ports.
    wr0(12'h020, 32'hFFFF_FFFF);
    exp_gnt.push_back(0);
    issue(0, 1'b1, 12'h020, 32'h1122_3344, 4'b0011, 1'b0);
    exp_gnt.push_back(0);
    exp_rsp0.push_back(32'hFFFF_3344);
    issue(0, 1'b0, 12'h020, '0, 4'h0, 1'b0);
    gap(2);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_rsp0.push_back(32'hFFFF_3344);
    fork
      issue(0, 1'b0, 12'h020, '0, 4'h0, 1'b0);
      issue(1, 1'b1, 12'h020, 32'h55AA_55AA, 4'hF, 1'b0);
    join
    exp_gnt.push_back(0);
    exp_rsp0.push_back(32'h55AA_55AA);
    issue(0, 1'b0, 12'h020, '0, 4'h0, 1'b0);
    gap(2);

`ifdef ARB_STATS_EN
    STAT_CLR = 1'b1;
    gap(1);
    STAT_CLR = 1'b0;
    @(negedge CLK);
    check("stat_clr_gnt0", 32'(stat_gnt0), '0);
    check("stat_clr_conflict", 32'(stat_conflict), '0);
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) begin
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
      exp_rsp0.push_back(32'hA000_0100 + i);
      exp_rsp1.push_back(32'hB000_0200 + i);
    end
    fork
      for (int i = 0; i < 2; i++) issue(0, 1'b0, 12'(12'h100 + i), '0, 4'h0, 1'b0);
      for (int j = 0; j < 2; j++) issue(1, 1'b0, 12'(12'h200 + j), '0, 4'h0, 1'b0);
    join
    gap(2);
    @(negedge CLK);
    check("stat_conflict", 32'(stat_conflict), 32'd3);
    check("stat_gnt0", 32'(stat_gnt0), 32'd2);
    check("stat_gnt1", 32'(stat_gnt1), 32'd2);
    @(posedge CLK); #1;
`endif

    // Reset right after a read accept drops its response.
    exp_gnt.push_back(0);
    issue(0, 1'b0, 12'h010, '0, 4'h0, 1'b0);
    RESET = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("rstmid_rsp0", 32'(bus.RSP0_VALID), '0);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_rst_rsp0", 32'(bus.RSP0_VALID), '0);
    end
`ifdef ARB_STATS_EN
    check("rst_stat_gnt0", 32'(stat_gnt0), '0);
    check("rst_stat_gnt1", 32'(stat_gnt1), '0);
    check("rst_stat_conflict", 32'(stat_conflict), '0);
`endif

    for (int i = 0; i < 20 && (exp_gnt.size() + exp_rsp0.size() + exp_rsp1.size()) != 0; i++)
      @(negedge CLK);
    check("queues_drained", 32'(exp_gnt.size() + exp_rsp0.size() + exp_rsp1.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
